// File: rtl/serial_alu.sv
// -----------------------------------------------------------------------------
// serial_alu
//   Bit-serial OR/AND/ADD/SUB unit. The operands are processed LSB first, one
//   bit per clock, through a single shared 1-bit logic/full-adder slice. The
//   parallel result is presented with a start/busy/done handshake.
//
// Parameters
//   WIDTH : operand/result width in bits (2..64)
//   CW    : bit-counter width, 2**CW >= WIDTH
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   start     : request a new operation (sampled only in IDLE)
//   op        : 00 OR, 01 AND, 10 ADD, 11 SUB (a-b)
//   a, b      : operands, sampled on the accepting edge
//   busy      : high while an operation is being processed
//   done      : one-cycle pulse, result/carry_out freshly updated
//   result    : last completed result, held until the next completion
//   carry_out : final carry of ADD/SUB (1 = no borrow for SUB), 0 for OR/AND
// -----------------------------------------------------------------------------
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, acc;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [1:0]       opr;

    logic             x, y, r, cy_nxt, last, arith;
    logic [WIDTH-1:0] acc_nxt;

    function automatic logic maj3(input logic p, input logic q, input logic s);
        return (p & q) | (p & s) | (q & s);
    endfunction

    // Shared 1-bit slice. SUB is a + ~b + 1: y is inverted here and the
    // carry register is preset to 1 on acceptance.
    always_comb begin
        arith  = opr[1];
        x      = sa[0];
        y      = sb[0] ^ (opr == OP_SUB);
        cy_nxt = maj3(x, y, cy);
        case (opr)
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
            default: r = x ^ y ^ cy;
        endcase
        acc_nxt = {r, acc[WIDTH-1:1]};
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            opr       <= OP_OR;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        opr <= op;
                        cnt <= '0;
                        acc <= '0;
                        cy  <= (op == OP_SUB);
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (arith) cy <= cy_nxt;
                    // The final bit goes straight into result rather than
                    // waiting a cycle for the accumulator to settle.
                    if (last) begin
                        result    <= acc_nxt;
                        carry_out <= arith & cy_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    serial_alu #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, {carry, result}.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        case (o)
            2'b00: s = {1'b0, x | y};
            2'b01: s = {1'b0, x & y};
            2'b10: s = {1'b0, x} + {1'b0, y};
            default: begin
                s[W-1:0] = x - y;
                s[W]     = (x >= y);
            end
        endcase
        return s;
    endfunction

    // Drives one operation and reports what was observed; comparisons are
    // made by the calling test.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int edges, output logic [W-1:0] r, output logic c,
                          output bit busy_ok, output bit stable_ok, output bit ends_clean);
        logic [W-1:0] prev;
        logic         prevc;
        @(negedge clk);
        prev = result; prevc = carry_out;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        edges = 0; busy_ok = 1; stable_ok = 1;
        while (done !== 1'b1 && edges < 30) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (result !== prev || carry_out !== prevc) stable_ok = 0;
            @(posedge clk); #1;
            edges++;
        end
        r = result; c = carry_out;
        @(posedge clk); #1;
        ends_clean = (done === 1'b0 && busy === 1'b0);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b result=%h carry=%b, required 0 0 00 0",
                     busy, done, result, carry_out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] er, input logic ec);
        int edges; logic [W-1:0] r; logic c; bit bok, sok, eok;
        run_op(o, x, y, edges, r, c, bok, sok, eok);
        checks++;
        if (r !== er || c !== ec) begin
            failures++;
            $display("FAIL %s_result: got %h/%b, required %h/%b", nm, r, c, er, ec);
        end
        checks++;
        if (edges !== W || !bok) begin
            failures++;
            $display("FAIL %s_latency: done after %0d edges busy_ok=%0b, required %0d edges busy_ok=1",
                     nm, edges, bok, W);
        end
        checks++;
        if (!sok || !eok) begin
            failures++;
            $display("FAIL %s_handshake: stable=%0b one_cycle_done=%0b, required 1 1", nm, sok, eok);
        end
    endtask

    task automatic test_or;  directed("or",  2'b00, 8'hA5, 8'h3C, 8'hBD, 1'b0); endtask
    task automatic test_and; directed("and", 2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0); endtask
    task automatic test_add;
        directed("add_wrap", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1);
        directed("add",      2'b10, 8'h12, 8'h34, 8'h46, 1'b0);
    endtask
    task automatic test_sub;
        directed("sub_borrow", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0);
        directed("sub",        2'b11, 8'h07, 8'h05, 8'h02, 1'b1);
        directed("sub_equal",  2'b11, 8'h80, 8'h80, 8'h00, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [1:0] o; logic [W-1:0] x, y; logic [W:0] e;
            int edges; logic [W-1:0] r; logic c; bit bok, sok, eok;
            o = 2'($urandom); x = W'($urandom); y = W'($urandom);
            e = model(o, x, y);
            run_op(o, x, y, edges, r, c, bok, sok, eok);
            checks++;
            if (r !== e[W-1:0] || c !== e[W] || edges !== W) begin
                failures++;
                $display("FAIL random op=%0d a=%h b=%h: got %h/%b in %0d edges, required %h/%b in %0d",
                         o, x, y, r, c, edges, e[W-1:0], e[W], W);
            end
        end
    endtask

    task automatic test_ignore_start;
        int n; int extra;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h21; b = 8'h43;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 8'h99; b = 8'h11;
        @(negedge clk);
        start = 1'b0; a = 8'h55; b = 8'hAA; op = 2'b00;
        n = 0;
        while (done !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
        checks++;
        if (done !== 1'b1 || result !== 8'h64 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: done=%b result=%h carry=%b, required 1 64 0", done, result, carry_out);
        end
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_not_queued: %0d active cycles after completion, required 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xs[4], ys[4];
        logic [W:0]   e;
        int           n, last_t, t;
        int           cyc;
        cyc = 0; last_t = -1;
        for (int i = 0; i < 4; i++) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = xs[0]; b = ys[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (done !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; cyc++; end
            t = cyc;
            e = model(2'b10, xs[i], ys[i]);
            checks++;
            if (result !== e[W-1:0] || carry_out !== e[W]) begin
                failures++;
                $display("FAIL b2b_result[%0d]: got %h/%b, required %h/%b", i, result, carry_out, e[W-1:0], e[W]);
            end
            if (i > 0) begin
                checks++;
                if (t - last_t != W + 2) begin
                    failures++;
                    $display("FAIL b2b_period[%0d]: %0d cycles, required %0d", i, t - last_t, W + 2);
                end
            end
            last_t = t;
            if (i < 3) begin a = xs[i+1]; b = ys[i+1]; end
            else start = 1'b0;
            @(posedge clk); #1; cyc++;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort;
        int seen;
        directed("pre_abort_or", 2'b00, 8'h0F, 8'hF0, 8'hFF, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h77; b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: busy=%b done=%b result=%h carry=%b, required 0 0 00 0",
                     busy, done, result, carry_out);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", seen);
        end
        directed("post_abort_sub", 2'b11, 8'h40, 8'h01, 8'h3F, 1'b1);
    endtask

    initial begin
        test_reset();
        test_or();
        test_and();
        test_add();
        test_sub();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
